dmem_arb: RTL and testbench

DMEM_ARB -- requirements
Module: dmem_arb

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arb_rr_pick2.sv | 26 ++
 rtl/dmem_arb.sv | 159 +++++++++++++++
 tb/tb_dmem_arb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Arbitration states, requester ids and width defaults.
package dmem_arb_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 32;

    typedef enum logic {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef enum logic {
        CORE = 1'b0,
        HOST = 1'b1
    } req_id_e;

endpackage

// File: rtl/dmem_arb_rr_pick2.sv
// Two-way round-robin picker.
// Favours the requester that was not served last.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic    req_c,
    input  logic    req_h,
    input  req_id_e last,
    output logic    pick_c,
    output logic    pick_h
);

    // Tie goes to whoever lost the previous grant.
    always_comb begin
        pick_c = 1'b0;
        pick_h = 1'b0;
        if (req_c && req_h) begin
            pick_c = (last == HOST);
            pick_h = (last == CORE);
        end else begin
            pick_c = req_c;
            pick_h = req_h;
        end
    end

endmodule

// File: rtl/dmem_arb.sv
// Core/host arbiter for a single-port data memory.
// Round-robin when free; host may lock, bounded by LOCK_MAX.
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int LOCK_MAX = 64
) (
    input  logic          clk_x,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          h_req,
    input  logic          h_we,
    input  logic          h_lock,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          lock_abort
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_e    state_q, state_d;
    req_id_e       rr_last_q, rr_last_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          rv_q, rv_d;
    req_id_e       rv_own_q, rv_own_d;
    logic          abort_q, abort_d;
    logic [DW-1:0] c_hold_q, c_hold_d;
    logic [DW-1:0] h_hold_q, h_hold_d;
    logic          pick_c, pick_h;
    logic          timeout;

    rr_pick2 u_pick (
        .req_c  (c_req),
        .req_h  (h_req),
        .last   (rr_last_q),
        .pick_c (pick_c),
        .pick_h (pick_h)
    );

    // Grants: round-robin when free, host only when locked; none in reset.
    always_comb begin
        c_gnt = 1'b0;
        h_gnt = 1'b0;
        if (rst) begin
            unique case (state_q)
                FREE: begin
                    c_gnt = pick_c;
                    h_gnt = pick_h;
                end
                LOCKED: h_gnt = h_req;
            endcase
        end
    end

    // Steer the winner onto the memory port; idle fields read as zero.
    always_comb begin
        m_en    = c_gnt | h_gnt;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (h_gnt) begin
            m_we    = h_we;
            m_addr  = h_addr;
            m_wdata = h_wdata;
        end else if (c_gnt) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end
    end

    // Lock counter: cleared on lock entry, counts stalled core cycles.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (state_q == FREE) begin
            if (h_gnt && h_lock) lock_cnt_d = '0;
        end else if (c_req && lock_cnt_q != CW'(LOCK_MAX)) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
        timeout = (state_q == LOCKED) && h_lock
                  && (lock_cnt_d == CW'(LOCK_MAX));
    end

    // Next state, round-robin pointer and abort pulse.
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        abort_d   = 1'b0;
        if (c_gnt) rr_last_d = CORE;
        if (h_gnt) rr_last_d = HOST;
        unique case (state_q)
            FREE: begin
                if (h_gnt && h_lock) state_d = LOCKED;
            end
            LOCKED: begin
                if (!h_lock) begin
                    state_d = FREE;
                end else if (timeout) begin
                    state_d   = FREE;
                    abort_d   = 1'b1;
                    rr_last_d = HOST;
                end
            end
        endcase
    end

    // Read response pipe and per-port held read data.
    always_comb begin
        rv_d     = m_en && !m_we;
        rv_own_d = h_gnt ? HOST : CORE;
        c_rvalid = rv_q && (rv_own_q == CORE);
        h_rvalid = rv_q && (rv_own_q == HOST);
        c_hold_d = c_rvalid ? m_rdata : c_hold_q;
        h_hold_d = h_rvalid ? m_rdata : h_hold_q;
        c_rdata  = c_hold_d;
        h_rdata  = h_hold_d;
        lock_abort = abort_q;
    end

    // State registers.
    always_ff @(posedge clk_x or negedge rst) begin
        if (!rst) begin
            state_q    <= FREE;
            rr_last_q  <= HOST;
            lock_cnt_q <= '0;
            rv_q       <= 1'b0;
            rv_own_q   <= CORE;
            abort_q    <= 1'b0;
            c_hold_q   <= '0;
            h_hold_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            lock_cnt_q <= lock_cnt_d;
            rv_q       <= rv_d;
            rv_own_q   <= rv_own_d;
            abort_q    <= abort_d;
            c_hold_q   <= c_hold_d;
            h_hold_q   <= h_hold_d;
        end
    end

endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: directed scenarios then random traffic,
// all outputs compared each cycle against a behavioural model.
module tb_dmem_arb;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int LM = 8;

    logic          clk_x = 1'b0;
    logic          rst = 1'b1;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          c_gnt, c_rvalid;
    logic [DW-1:0] c_rdata;
    logic          h_req = 1'b0, h_we = 1'b0, h_lock = 1'b0;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_wdata = '0;
    logic          h_gnt, h_rvalid;
    logic [DW-1:0] h_rdata;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;
    logic          lock_abort;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit          md_locked, md_last_host, md_pv, md_ph, md_abort;
    int          md_lock_cycles;
    logic [31:0] md_pd, md_ch, md_hh;

    // values observed in the last tick
    logic        obs_cg, obs_hg, obs_crv, obs_hrv, obs_abort;
    logic [31:0] obs_crd, obs_hrd;

    dmem_arb #(.AW(AW), .DW(DW), .LOCK_MAX(LM)) dut (
        .clk_x(clk_x), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .h_req(h_req), .h_we(h_we), .h_lock(h_lock), .h_addr(h_addr),
        .h_wdata(h_wdata), .h_gnt(h_gnt), .h_rvalid(h_rvalid),
        .h_rdata(h_rdata), .m_en(m_en), .m_we(m_we), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .lock_abort(lock_abort)
    );

    initial forever #5 clk_x = ~clk_x;

    function automatic logic [31:0] memf(input logic [AW-1:0] a);
        if (a == 10'd3) return 32'h1234_5678;
        return 32'hA5C3_0000 ^ ({22'd0, a} * 32'h0001_0007);
    endfunction

    // memory: read data one cycle after a read enable, junk otherwise
    always @(posedge clk_x) begin
        if (m_en && !m_we) m_rdata <= memf(m_addr);
        else m_rdata <= $urandom;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        md_locked = 0;
        md_last_host = 1;
        md_lock_cycles = 0;
        md_pv = 0;
        md_ph = 0;
        md_pd = '0;
        md_abort = 0;
        md_ch = '0;
        md_hh = '0;
    endtask

    // One clock: check all outputs against the model, then advance it.
    task automatic tick();
        bit eg_c, eg_h, ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        #1;
        if (!rst) model_reset();
        eg_c = 0;
        eg_h = 0;
        if (rst) begin
            if (md_locked) eg_h = h_req;
            else if (c_req && h_req) begin
                eg_c = md_last_host;
                eg_h = !md_last_host;
            end else begin
                eg_c = c_req;
                eg_h = h_req;
            end
        end
        ew = 0;
        ea = '0;
        ed = '0;
        if (eg_h) begin
            ew = h_we; ea = h_addr; ed = h_wdata;
        end else if (eg_c) begin
            ew = c_we; ea = c_addr; ed = c_wdata;
        end
        chk("c_gnt", c_gnt, eg_c);
        chk("h_gnt", h_gnt, eg_h);
        chk("m_en", m_en, eg_c | eg_h);
        chk("m_we", m_we, ew);
        chk("m_addr", m_addr, ea);
        chk("m_wdata", m_wdata, ed);
        chk("c_rvalid", c_rvalid, md_pv && !md_ph);
        chk("h_rvalid", h_rvalid, md_pv && md_ph);
        chk("c_rdata", c_rdata, (md_pv && !md_ph) ? md_pd : md_ch);
        chk("h_rdata", h_rdata, (md_pv && md_ph) ? md_pd : md_hh);
        chk("lock_abort", lock_abort, md_abort);
        obs_cg = c_gnt;
        obs_hg = h_gnt;
        obs_crv = c_rvalid;
        obs_hrv = h_rvalid;
        obs_crd = c_rdata;
        obs_hrd = h_rdata;
        obs_abort = lock_abort;
        @(posedge clk_x);
        if (rst) begin
            if (md_pv && !md_ph) md_ch = md_pd;
            if (md_pv && md_ph) md_hh = md_pd;
            md_pv = (eg_c || eg_h) && !ew;
            md_ph = eg_h;
            md_pd = memf(ea);
            md_abort = 0;
            if (eg_c) md_last_host = 0;
            if (eg_h) md_last_host = 1;
            if (!md_locked) begin
                if (eg_h && h_lock) begin
                    md_locked = 1;
                    md_lock_cycles = 0;
                end
            end else if (!h_lock) begin
                md_locked = 0;
            end else if (c_req) begin
                md_lock_cycles++;
                if (md_lock_cycles == LM) begin
                    md_locked = 0;
                    md_abort = 1;
                    md_last_host = 1;
                end
            end
        end
        #2;
    endtask

    task automatic idle();
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        h_req = 0; h_we = 0; h_lock = 0; h_addr = '0; h_wdata = '0;
    endtask

    initial begin
        model_reset();
        idle();
        #1 rst = 0;
        #6;
        tick();
        tick();
        rst = 1;
        tick();

        // core-only read of addr 3
        c_req = 1; c_we = 0; c_addr = 10'd3;
        tick();
        chk("rd3_gnt", obs_cg, 1'b1);
        c_req = 0;
        tick();
        chk("rd3_rvalid", obs_crv, 1'b1);
        chk("rd3_rdata", obs_crd, 32'h1234_5678);
        chk("rd3_h_rvalid", obs_hrv, 1'b0);

        // both writing after reset: core, host, core, host
        rst = 0;
        tick();
        rst = 1;
        c_req = 1; c_we = 1; c_addr = 10'($urandom); c_wdata = $urandom;
        h_req = 1; h_we = 1; h_addr = 10'($urandom); h_wdata = $urandom;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alt_core", obs_cg, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("alt_host", obs_hg, (i % 2 == 1) ? 1'b1 : 1'b0);
            if (obs_cg) begin c_addr = 10'($urandom); c_wdata = $urandom; end
            if (obs_hg) begin h_addr = 10'($urandom); h_wdata = $urandom; end
        end
        idle();

        // lock with core stalled until timeout
        c_req = 1; c_we = 1; c_addr = 10'd9; c_wdata = 32'h1;
        tick();
        c_we = 0; c_addr = 10'd11;
        h_req = 1; h_we = 1; h_lock = 1; h_addr = 10'd12;
        tick();
        chk("lock_hgnt", obs_hg, 1'b1);
        h_req = 0;
        for (int i = 0; i < LM; i++) begin
            tick();
            chk("lock_cgnt0", obs_cg, 1'b0);
            chk("lock_noabort", obs_abort, 1'b0);
        end
        tick();
        chk("abort_pulse", obs_abort, 1'b1);
        chk("abort_cgnt", obs_cg, 1'b1);
        idle();
        tick();
        chk("abort_once", obs_abort, 1'b0);

        // host read 5 then core read 6 back to back
        h_req = 1; h_we = 0; h_addr = 10'd5;
        tick();
        h_req = 0;
        c_req = 1; c_we = 0; c_addr = 10'd6;
        tick();
        chk("b2b_hrv", obs_hrv, 1'b1);
        chk("b2b_hrd", obs_hrd, memf(10'd5));
        chk("b2b_crv0", obs_crv, 1'b0);
        c_req = 0;
        tick();
        chk("b2b_crv", obs_crv, 1'b1);
        chk("b2b_crd", obs_crd, memf(10'd6));
        chk("b2b_hrv0", obs_hrv, 1'b0);

        // reset right after a core read grant
        c_req = 1; c_we = 0; c_addr = 10'd7;
        tick();
        c_req = 0;
        rst = 0;
        tick();
        chk("rst_crv", obs_crv, 1'b0);
        rst = 1;
        tick();
        chk("rst_crv_after", obs_crv, 1'b0);
        tick();

        // random traffic honouring hold-until-grant
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if (!c_req || obs_cg) begin
                c_req = ($urandom_range(0, 99) < 60);
                c_we = 1'($urandom_range(0, 1));
                c_addr = 10'($urandom);
                c_wdata = $urandom;
            end
            if (!h_req || obs_hg) begin
                h_req = ($urandom_range(0, 99) < 50);
                h_we = 1'($urandom_range(0, 1));
                h_lock = ($urandom_range(0, 99) < 75);
                h_addr = 10'($urandom);
                h_wdata = $urandom;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
